// File: rtl/cadence_pkg.sv
// Shared types and default sizes for the cadence line generator.
package cadence_pkg;

    // Default widths: half-period count, bounce segment length,
    // glitch-count field and clean-rising-edge counter.
    localparam int PER_W_DEF = 24;
    localparam int GL_W_DEF  = 8;
    localparam int NG_W_DEF  = 3;
    localparam int CNT_W_DEF = 16;

    // Generator phases. IDLE holds the line low. LOW and HIGH are the clean
    // half-periods. BNC_R and BNC_F are the bounce bursts at the rising and
    // falling edges.
    typedef enum logic [2:0] {
        IDLE,
        LOW,
        BNC_R,
        HIGH,
        BNC_F
    } cad_gen_state_t;

endpackage

// File: rtl/cadence_gen_phase_timer.sv
// Loadable down-counter that times clean phases and bounce segments.
// Loading len-1 on phase entry makes done rise on the last cycle of the phase.
module phase_timer
    import cadence_pkg::*;
#(
    parameter int PER_W = PER_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [PER_W-1:0] load_val,
    output logic             done
);

    logic [PER_W-1:0] cnt_q;

    // Count down toward zero, reloading whenever a new phase or segment starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - PER_W'(1);
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/cadence_gen.sv
// Programmable pedal-cadence emulator. It produces a square wave on the
// cadence line and can add contact bounce at each edge. The configuration
// is shadowed so that a period in progress is never distorted.
module cadence_gen
    import cadence_pkg::*;
#(
    parameter int PER_W = PER_W_DEF,
    parameter int GL_W  = GL_W_DEF,
    parameter int NG_W  = NG_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [PER_W-1:0] half_per,
    input  logic [NG_W-1:0]  num_glitch,
    input  logic [GL_W-1:0]  glitch_len,
    input  logic             clr_cnt,
    output logic             cadence,
    output logic [CNT_W-1:0] rise_cnt,
    output logic             busy
);

    localparam int SEG_W = NG_W + 1;

    cad_gen_state_t state_q, state_d;

    logic [PER_W-1:0] hp_q, hp_d;
    logic [NG_W-1:0]  ng_q, ng_d;
    logic [GL_W-1:0]  gl_q, gl_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    logic             cad_q, cad_d;
    logic             busy_q;
    logic [CNT_W-1:0] rise_q, rise_d;

    logic             tmr_load;
    logic [PER_W-1:0] tmr_val;
    logic             tmr_done;
    logic             last_seg;

    // A zero segment length behaves like a length of one, so it loads zero.
    function automatic logic [PER_W-1:0] seg_load(input logic [GL_W-1:0] g);
        logic [PER_W-1:0] r;
        r = '0;
        if (g != '0) begin
            r = PER_W'(g - GL_W'(1));
        end
        return r;
    endfunction

    phase_timer #(
        .PER_W (PER_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // A burst is 2*num_glitch segments, indexed 0 .. 2*num_glitch-1.
    assign last_seg = (seg_q == ({ng_q, 1'b0} - SEG_W'(1)));

    // Sequence the phases, shadow the config, and compute the next line level.
    always_comb begin
        state_d  = state_q;
        hp_d     = hp_q;
        ng_d     = ng_q;
        gl_d     = gl_q;
        seg_d    = seg_q;
        cad_d    = cad_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            IDLE: begin
                cad_d = 1'b0;
                if (en && (half_per != '0)) begin
                    hp_d     = half_per;
                    ng_d     = num_glitch;
                    gl_d     = glitch_len;
                    state_d  = LOW;
                    tmr_load = 1'b1;
                    tmr_val  = half_per - PER_W'(1);
                end
            end
            LOW: begin
                if (tmr_done) begin
                    if (!en) begin
                        state_d = IDLE;
                        cad_d   = 1'b0;
                    end else begin
                        hp_d = half_per;
                        ng_d = num_glitch;
                        gl_d = glitch_len;
                        if (half_per == '0) begin
                            state_d = IDLE;
                            cad_d   = 1'b0;
                        end else if (num_glitch != '0) begin
                            state_d  = BNC_R;
                            seg_d    = '0;
                            tmr_load = 1'b1;
                            tmr_val  = seg_load(glitch_len);
                            cad_d    = 1'b1;
                        end else begin
                            state_d  = HIGH;
                            tmr_load = 1'b1;
                            tmr_val  = half_per - PER_W'(1);
                            cad_d    = 1'b1;
                        end
                    end
                end
            end
            BNC_R: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    if (last_seg) begin
                        state_d = HIGH;
                        tmr_val = hp_q - PER_W'(1);
                        cad_d   = 1'b1;
                    end else begin
                        seg_d   = seg_q + SEG_W'(1);
                        tmr_val = seg_load(gl_q);
                        cad_d   = seg_q[0];
                    end
                end
            end
            HIGH: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    cad_d    = 1'b0;
                    if (ng_q != '0) begin
                        state_d = BNC_F;
                        seg_d   = '0;
                        tmr_val = seg_load(gl_q);
                    end else begin
                        state_d = LOW;
                        tmr_val = hp_q - PER_W'(1);
                    end
                end
            end
            BNC_F: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    if (last_seg) begin
                        state_d = LOW;
                        tmr_val = hp_q - PER_W'(1);
                        cad_d   = 1'b0;
                    end else begin
                        seg_d   = seg_q + SEG_W'(1);
                        tmr_val = seg_load(gl_q);
                        cad_d   = ~seg_q[0];
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cad_d   = 1'b0;
            end
        endcase
    end

    // Count entries into HIGH, saturating. A clear takes priority over a count.
    always_comb begin
        rise_d = rise_q;
        if (clr_cnt) begin
            rise_d = '0;
        end else if ((state_d == HIGH) && (state_q != HIGH) && (rise_q != '1)) begin
            rise_d = rise_q + CNT_W'(1);
        end
    end

    // Register the state, the shadow config, the line level and the status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hp_q    <= '0;
            ng_q    <= '0;
            gl_q    <= '0;
            seg_q   <= '0;
            cad_q   <= 1'b0;
            busy_q  <= 1'b0;
            rise_q  <= '0;
        end else begin
            state_q <= state_d;
            hp_q    <= hp_d;
            ng_q    <= ng_d;
            gl_q    <= gl_d;
            seg_q   <= seg_d;
            cad_q   <= cad_d;
            busy_q  <= (state_d != IDLE);
            rise_q  <= rise_d;
        end
    end

    assign cadence  = cad_q;
    assign busy     = busy_q;
    assign rise_cnt = rise_q;

endmodule

// File: tb/tb_cadence_gen.sv
// Directed bench for cadence_gen: waveform shapes, shadowing, enable drop,
// invalid period, counter saturation and clear, and asynchronous reset.
module tb_cadence_gen;

   logic        clk;
   logic        rstN;
   logic        en;
   logic [23:0] halfPer;
   logic [2:0]  numGlitch;
   logic [7:0]  glitchLen;
   logic        clrCnt;
   logic        cadence;
   logic [3:0]  riseCnt;
   logic        busy;

   int assertCount;
   int failCount;

   cadence_gen #(
      .PER_W (24),
      .GL_W  (8),
      .NG_W  (3),
      .CNT_W (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rstN),
      .en         (en),
      .half_per   (halfPer),
      .num_glitch (numGlitch),
      .glitch_len (glitchLen),
      .clr_cnt    (clrCnt),
      .cadence    (cadence),
      .rise_cnt   (riseCnt),
      .busy       (busy)
   );

   // Free-running clock with a 10-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic e, input logic [23:0] hp, input logic [2:0] ng,
                                input logic [7:0] gl, input logic clr);
      en        = e;
      halfPer   = hp;
      numGlitch = ng;
      glitchLen = gl;
      clrCnt    = clr;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic resetDut();
      @(posedge clk);
      #2;
      applyStimulus(1'b0, 24'd0, 3'd0, 8'd0, 1'b0);
      rstN = 1'b0;
      waitCycles(2);
      rstN = 1'b1;
   endtask

   // Each character covers one cycle. '0' and '1' are the line level while busy; 'i' means idle.
   task automatic expectSeq(input string tag, input string pat);
      for (int i = 0; i < pat.len(); i++) begin
         waitCycles(1);
         if (pat[i] == "i") begin
            checkOutput($sformatf("%s[%0d].cad", tag, i), 32'(cadence), 32'd0);
            checkOutput($sformatf("%s[%0d].busy", tag, i), 32'(busy), 32'd0);
         end else begin
            checkOutput($sformatf("%s[%0d].cad", tag, i), 32'(cadence), (pat[i] == "1") ? 32'd1 : 32'd0);
            checkOutput($sformatf("%s[%0d].busy", tag, i), 32'(busy), 32'd1);
         end
      end
   endtask

   initial begin
      assertCount = 0;
      failCount   = 0;
      rstN        = 1'b0;
      applyStimulus(1'b0, 24'd0, 3'd0, 8'd0, 1'b0);

      // Reset values.
      #12;
      checkOutput("rst.cad", 32'(cadence), 32'd0);
      checkOutput("rst.busy", 32'(busy), 32'd0);
      checkOutput("rst.rise", 32'(riseCnt), 32'd0);
      rstN = 1'b1;

      // Clean square wave with half-period 4.
      resetDut();
      applyStimulus(1'b1, 24'd4, 3'd0, 8'd0, 1'b0);
      expectSeq("clean", "0000111100001111");
      checkOutput("clean.rise", 32'(riseCnt), 32'd2);

      // Bounce: half_per 2, two glitches of 3 cycles each.
      resetDut();
      applyStimulus(1'b1, 24'd2, 3'd2, 8'd3, 1'b0);
      expectSeq("bnc.a", "00111000111000");
      checkOutput("bnc.rise0", 32'(riseCnt), 32'd0);
      expectSeq("bnc.b", "1100011100011100");
      checkOutput("bnc.rise1", 32'(riseCnt), 32'd1);

      // Drop en during HIGH: the period completes, then the line goes idle.
      resetDut();
      applyStimulus(1'b1, 24'd4, 3'd0, 8'd0, 1'b0);
      expectSeq("endrop.a", "000011");
      applyStimulus(1'b0, 24'd4, 3'd0, 8'd0, 1'b0);
      expectSeq("endrop.b", "110000iii");
      checkOutput("endrop.rise", 32'(riseCnt), 32'd1);

      // Change half_per during HIGH: the following LOW keeps 4, the next HIGH uses 9.
      resetDut();
      applyStimulus(1'b1, 24'd4, 3'd0, 8'd0, 1'b0);
      expectSeq("shadow.a", "000011");
      applyStimulus(1'b1, 24'd9, 3'd0, 8'd0, 1'b0);
      expectSeq("shadow.b", "110000111111111000000000");
      checkOutput("shadow.rise", 32'(riseCnt), 32'd2);

      // half_per 0 stays idle. Then glitch_len 0 gives one-cycle bounce segments.
      resetDut();
      applyStimulus(1'b1, 24'd0, 3'd1, 8'd0, 1'b0);
      expectSeq("hp0", "iiii");
      checkOutput("hp0.rise", 32'(riseCnt), 32'd0);
      applyStimulus(1'b1, 24'd2, 3'd1, 8'd0, 1'b0);
      expectSeq("gl0", "0010110100");

      // Saturation with a 4-bit counter, then a clear on a HIGH-entry cycle.
      resetDut();
      applyStimulus(1'b1, 24'd1, 3'd0, 8'd0, 1'b0);
      waitCycles(40);
      checkOutput("sat.rise", 32'(riseCnt), 32'd15);
      checkOutput("sat.cad", 32'(cadence), 32'd1);
      waitCycles(1);
      clrCnt = 1'b1;
      waitCycles(1);
      clrCnt = 1'b0;
      checkOutput("clr.rise", 32'(riseCnt), 32'd0);
      checkOutput("clr.cad", 32'(cadence), 32'd1);
      waitCycles(2);
      checkOutput("clr.next", 32'(riseCnt), 32'd1);

      // Asynchronous reset in the middle of BNC_R, then a clean restart.
      resetDut();
      applyStimulus(1'b1, 24'd2, 3'd2, 8'd3, 1'b0);
      waitCycles(32);
      checkOutput("arst.pre.cad", 32'(cadence), 32'd1);
      checkOutput("arst.pre.rise", 32'(riseCnt), 32'd1);
      rstN = 1'b0;
      #1;
      checkOutput("arst.cad", 32'(cadence), 32'd0);
      checkOutput("arst.busy", 32'(busy), 32'd0);
      checkOutput("arst.rise", 32'(riseCnt), 32'd0);
      #2;
      rstN = 1'b1;
      expectSeq("arst.restart", "00111000111000");

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
